inc_share_ctrl: RTL and testbench
=================================

Name: inc_share_ctrl

Overview:
- Arbitration and sequencing controller that time-shares one 16-bit ripple-carry incrementer datapath between NUM_REQ requesters.
- Selects a requester round-robin, captures its operand and runs one increment.
- Returns the result with a valid/ready response handshake tagged with the requester ID.
- Sits between client blocks (counters, address generators) and the single shared sixteenBitIncrementer instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ)).
- DATA_W, 16, operand width; only 16 supported, matching the incrementer datapath.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NUM_REQ  per-requester request level.
- operand  input  NUM_REQ*DATA_W  packed operands; requester i uses bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot, one-cycle grant pulse.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted by consumer.
- rsp_result  output  DATA_W  operand+1.
- rsp_carry  output  1  carry out of bit 15.
- rsp_id  output  ID_W  index of the served requester.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, ptr=0, gnt=0.
  - rsp_valid=0, rsp_result=0x0000, rsp_carry=0, rsp_id=0, busy=0.
  - Any in-flight operation or pending response is discarded.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req is nonzero at the edge, the winner is the first set bit searching from ptr upward with wrap.
  - On that edge: op_reg<=operand[winner], id_reg<=winner, gnt[winner]<=1, state->EXEC.
  - If req is all zero, stay in IDLE.
- EXEC (gnt is high for exactly this cycle):
  - Incrementer input is op_reg.
  - On the edge: rsp_result<=sum, rsp_carry<=carry, rsp_id<=id_reg, rsp_valid<=1, gnt<=0, state->RESP.
- RESP:
  - rsp_valid, rsp_result, rsp_carry and rsp_id hold stable until rsp_valid && rsp_ready.
  - On the accepting edge: rsp_valid<=0, ptr<=(id_reg+1) mod NUM_REQ, state->IDLE.
- Latency: req sampled at edge 0 -> gnt high in cycle 1 -> rsp_valid high in cycle 2 -> earliest next grant in cycle 4 when rsp_ready is held high. Maximum throughput is one operation per 3 cycles.
- Requester protocol:
  - Hold req and operand stable until gnt is seen.
  - Deassert req in the cycle after gnt, or it is re-arbitrated as a new request.
  - A req dropped before capture is simply not served; no error is raised.
- rsp_ready while rsp_valid=0 is ignored.
- req changes during EXEC or RESP have no effect; arbitration occurs only in IDLE.
- Wrap: operand 0xFFFF -> rsp_result=0x0000, rsp_carry=1. All other operands give rsp_carry=0.
- Fairness: a requester held high is served within NUM_REQ grants.
- ptr advances only on response acceptance, never on grant.

Optional Feature:
- Macro: INC_SATURATE_EN.
- Defined: operand 0xFFFF -> rsp_result=0xFFFF with rsp_carry=1, as an overflow flag. Implemented as a mux after the incrementer, gated by carry.
- Undefined: wrap-around as specified above; no mux logic is present.

Decomposition:
- Package inc_share_pkg holds:
  - state enum (IDLE, EXEC, RESP);
  - DATA_W constant = 16;
  - the ID-width helper function.
- Sub-module rr_arbiter (combinational round-robin pick), with inputs req and ptr and outputs the winner index and an any_req flag.
- Datapath: a single instantiation of the team's sixteenBitIncrementer, with a = op_reg, b = sum, finalcarry = carry.

Test Plan:
- Reset with req=4'b1111 held -> gnt, rsp_valid and busy stay 0. After release, the first gnt is 4'b0001 with operand[0]=0x0010 -> rsp_result=0x0011, rsp_id=0 in cycle 2.
- All four requesters held with rsp_ready=1 -> grant order 0,1,2,3,0, each grant spaced 3 cycles apart.
- operand[2]=0xFFFF, only req[2] set -> rsp_result=0x0000, rsp_carry=1, rsp_id=2. With INC_SATURATE_EN: rsp_result=0xFFFF, rsp_carry=1.
- rsp_ready held 0 for 5 cycles with operand[1]=0x7FFF -> rsp_valid stays high and rsp_result stays 0x8000. No gnt is issued despite req[3]=1; gnt[3] follows after acceptance.
- rst_n pulsed low during RESP -> rsp_valid drops immediately (asynchronously), ptr=0, and the next arbitration restarts from requester 0.
- req[1] raised, then dropped before the clock edge in IDLE -> no gnt, state remains IDLE, busy=0.

Source files
------------

// File: rtl/inc_share_pkg.sv
// Shared types and constants for the incrementer-sharing controller.
package inc_share_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } ctrlState_e;

    // Width needed to index n requesters (never less than one bit).
    function automatic int idWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/inc_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               anyReq
);

    import inc_share_pkg::*;

    int unsigned idx;

    // Scan offsets from the farthest down to zero so the nearest request wins.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            idx = (int'(ptr) + k - 1) % NUM_REQ;
            if (req[ID_W'(idx)]) winner = ID_W'(idx);
        end
    end

    assign anyReq = |req;

endmodule

// File: rtl/sixteenBitIncrementer.sv
// 16-bit ripple-carry incrementer: b = a + 1, finalcarry = carry out of bit 15.
module sixteenBitIncrementer (
    input  logic [15:0] a,
    output logic [15:0] b,
    output logic        finalcarry
);

    logic [16:0] chain;

    always_comb begin
        chain    = '0;
        b        = '0;
        chain[0] = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            b[i]       = a[i] ^ chain[i];
            chain[i+1] = a[i] & chain[i];
        end
        finalcarry = chain[16];
    end

endmodule

// File: rtl/inc_share_ctrl.sv
// Time-shares one sixteenBitIncrementer between NUM_REQ requesters with a tagged response handshake.
// Optional INC_SATURATE_EN: saturate 0xFFFF instead of wrapping (carry still flags overflow).
module inc_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = inc_share_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] operand,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_carry,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    import inc_share_pkg::*;

    if (ID_W != idWidth(NUM_REQ)) begin : gBadIdW
        $error("ID_W must equal ceil(log2(NUM_REQ))");
    end
    if (DATA_W != 16) begin : gBadDataW
        $error("only DATA_W = 16 is supported");
    end

    ctrlState_e        state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   idReg;
    logic [DATA_W-1:0] opReg;
    logic [ID_W-1:0]   winner;
    logic              anyReq;
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic [DATA_W-1:0] result;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) uArb (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .anyReq (anyReq)
    );

    sixteenBitIncrementer uInc (
        .a          (opReg),
        .b          (sum),
        .finalcarry (carry)
    );

`ifdef INC_SATURATE_EN
    assign result = carry ? '1 : sum;
`else
    assign result = sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            idReg      <= '0;
            opReg      <= '0;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_id     <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        opReg <= operand[winner*DATA_W +: DATA_W];
                        idReg <= winner;
                        gnt   <= NUM_REQ'(1) << winner;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= result;
                    rsp_carry  <= carry;
                    rsp_id     <= idReg;
                    rsp_valid  <= 1'b1;
                    gnt        <= '0;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        ptr       <= (idReg == ID_W'(NUM_REQ - 1)) ? '0 : idReg + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inc_share_ctrl.sv
// Randomized self-checking bench for inc_share_ctrl against a transaction-level reference model.
module tb_inc_share_ctrl;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] operand;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_carry;
    logic [1:0]     rsp_id;
    logic           busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mPtr = 0;
    int          gntCyc = 0;
    logic [15:0] ops [N];

    inc_share_ctrl #(
        .NUM_REQ (N),
        .ID_W    (2),
        .DATA_W  (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .operand    (operand),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic driveOps;
        for (int i = 0; i < N; i++) operand[i*W +: W] = ops[i];
    endtask

    function automatic int expWinner(input logic [N-1:0] mask, input int p);
        for (int k = 0; k < N; k++) begin
            if (mask[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // One full transaction: grant edge, execute edge, optional stalls, accept edge.
    task automatic runTxn(input logic [N-1:0] mask, input logic [N-1:0] busyReq, input int stalls);
        int          win;
        logic [16:0] s;
        logic [15:0] expRes;
        logic        expCarry;
        req = mask;
        driveOps();
        win      = expWinner(mask, mPtr);
        s        = {1'b0, ops[win]} + 17'd1;
        expRes   = s[15:0];
        expCarry = s[16];
`ifdef INC_SATURATE_EN
        if (expCarry) expRes = 16'hFFFF;
`endif
        tick();
        gntCyc = cyc;
        checkVal("gnt", 32'(gnt), 32'(1) << win);
        checkVal("busyAtGnt", 32'(busy), 1);
        checkVal("validAtGnt", 32'(rsp_valid), 0);
        req = busyReq;
        for (int i = 0; i < N; i++) ops[i] = 16'($urandom);
        driveOps();
        rsp_ready = 1'($urandom_range(0, 1));
        tick();
        checkVal("gntDrop", 32'(gnt), 0);
        checkVal("valid", 32'(rsp_valid), 1);
        checkVal("result", 32'(rsp_result), 32'(expRes));
        checkVal("carry", 32'(rsp_carry), 32'(expCarry));
        checkVal("id", 32'(rsp_id), 32'(win));
        for (int st = 0; st < stalls; st++) begin
            rsp_ready = 1'b0;
            req = 4'($urandom);
            tick();
            checkVal("holdValid", 32'(rsp_valid), 1);
            checkVal("holdResult", 32'(rsp_result), 32'(expRes));
            checkVal("holdId", 32'(rsp_id), 32'(win));
            checkVal("holdNoGnt", 32'(gnt), 0);
        end
        rsp_ready = 1'b1;
        tick();
        checkVal("acceptValid", 32'(rsp_valid), 0);
        checkVal("acceptBusy", 32'(busy), 0);
        checkVal("acceptGnt", 32'(gnt), 0);
        mPtr = (win + 1) % N;
    endtask

    initial begin
        int prevGnt;
        rst_n = 1'b0;
        req = 4'b1111;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) ops[i] = 16'($urandom);
        ops[0] = 16'h0010;
        driveOps();

        // Reset held with all requests asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal("rstGnt", 32'(gnt), 0);
            checkVal("rstValid", 32'(rsp_valid), 0);
            checkVal("rstBusy", 32'(busy), 0);
            checkVal("rstResult", 32'(rsp_result), 0);
            checkVal("rstCarry", 32'(rsp_carry), 0);
            checkVal("rstId", 32'(rsp_id), 0);
        end
        rst_n = 1'b1;
        mPtr = 0;
        runTxn(4'b1111, 4'b0000, 0);

        // Round-robin order with all requesters held and ready high
        rst_n = 1'b0;
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        mPtr = 0;
        prevGnt = 0;
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < N; i++) ops[i] = 16'($urandom);
            runTxn(4'b1111, 4'b1111, 0);
            if (t > 0) checkVal("spacing", 32'(gntCyc - prevGnt), 3);
            prevGnt = gntCyc;
        end

        // Wrap at 0xFFFF
        req = 4'b0000;
        tick();
        ops[2] = 16'hFFFF;
        runTxn(4'b0100, 4'b0000, 1);

        // Long stall with a competing request during RESP
        ops[1] = 16'h7FFF;
        runTxn(4'b0010, 4'b1000, 5);
        runTxn(4'b1000, 4'b0000, 0);

        // Async reset during RESP restarts arbitration from requester 0
        runTxn(4'b0100, 4'b0000, 0);
        req = 4'b1000;
        tick();
        checkVal("preRstGnt", 32'(gnt), 32'b1000);
        req = 4'b0000;
        tick();
        checkVal("preRstValid", 32'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        checkVal("asyncValid", 32'(rsp_valid), 0);
        checkVal("asyncBusy", 32'(busy), 0);
        checkVal("asyncResult", 32'(rsp_result), 0);
        tick();
        rst_n = 1'b1;
        mPtr = 0;
        runTxn(4'b1111, 4'b0000, 0);

        // Request pulse that vanishes before the edge
        req = 4'b0010;
        #2;
        req = 4'b0000;
        tick();
        checkVal("pulseGnt", 32'(gnt), 0);
        checkVal("pulseBusy", 32'(busy), 0);
        tick();
        checkVal("pulseGnt2", 32'(gnt), 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0:       ops[i] = 16'hFFFF;
                    1:       ops[i] = 16'h7FFF;
                    default: ops[i] = 16'($urandom);
                endcase
            end
            runTxn(4'($urandom_range(1, 15)), 4'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                req = 4'b0000;
                tick();
                checkVal("idleGnt", 32'(gnt), 0);
                checkVal("idleBusy", 32'(busy), 0);
                checkVal("idleValid", 32'(rsp_valid), 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
